// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer
//   Top-level game-flow FSM: START -> PRELEVEL -> PLAY(level k) -> WIN / GAME_OVER
//   over NUM_LEVELS levels. Owns the lives count, selects the active screen/level
//   for the renderer mux, gates inputs into the active level and pulses a
//   per-level restart on PLAY entry.
// Ports
//   vga_clock     in   system clock
//   reset         in   synchronous, active-high reset
//   start_button  in   KEY, active-low, already synchronised
//   level_win     in   active level reached its goal (sampled only in PLAY)
//   level_lose    in   active level reports death (sampled only in PLAY)
//   screen        out  0 START, 1 PRELEVEL, 2 PLAY, 3 WIN, 4 GAME_OVER
//   level_index   out  index of current/next level
//   level_enable  out  1 only in PLAY
//   level_restart out  one-cycle pulse on the first PLAY cycle
//   lives         out  remaining lives
//   show_hearts   out  1 in PRELEVEL and PLAY
//   leds          out  [9:6] one-hot lives==3,2,1,0; [5:0] level_index one-hot
module game_flow_sequencer #(
    parameter int NUM_LEVELS       = 3,
    parameter int START_LIVES      = 3,
    parameter int LIVES_W          = 2,
    parameter int PRELEVEL_HOLD    = 50_000_000,
    parameter int RETRY_FROM_START = 0,
    parameter int LEVEL_W          = ($clog2(NUM_LEVELS) > 0) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic               vga_clock,
    input  logic               reset,
    input  logic               start_button,
    input  logic               level_win,
    input  logic               level_lose,
    output logic [2:0]         screen,
    output logic [LEVEL_W-1:0] level_index,
    output logic               level_enable,
    output logic               level_restart,
    output logic [LIVES_W-1:0] lives,
    output logic               show_hearts,
    output logic [9:0]         leds
);

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_PRELEVEL  = 3'd1,
        S_PLAY      = 3'd2,
        S_WIN       = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam int                 HOLD_W     = (PRELEVEL_HOLD > 1) ? $clog2(PRELEVEL_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'((PRELEVEL_HOLD > 0) ? PRELEVEL_HOLD - 1 : 0);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

    state_t             state, next_state;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LIVES_W-1:0] lives_q, lives_d, lives_dec;
    logic [HOLD_W-1:0]  hold_cnt, hold_d;
    logic               restart_q, restart_d;
    logic               start_prev, start_armed, start_press;

    // start_armed only rises once the button has actually been seen released
    // after reset, so a key held low through reset cannot fake a press even
    // though start_prev resets to the released level.
    always_comb begin
        start_press = start_armed & start_prev & ~start_button;
        next_state  = state;
        level_d     = level_q;
        lives_d     = lives_q;
        hold_d      = '0;
        lives_dec   = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);

        case (state)
            S_START: begin
                if (start_press) begin
                    next_state = S_PRELEVEL;
                    level_d    = '0;
                end
            end
            S_PRELEVEL: begin
                hold_d = hold_cnt + HOLD_W'(1);
                if (start_press || (PRELEVEL_HOLD != 0 && hold_cnt == HOLD_LAST)) begin
                    next_state = S_PLAY;
                    hold_d     = '0;
                end
            end
            S_PLAY: begin
                // restart_q marks the entry cycle: level status is stale then.
                if (!restart_q) begin
                    if (level_win) begin
                        if (level_q == LAST_LEVEL) begin
                            next_state = S_WIN;
                        end else begin
                            next_state = S_PRELEVEL;
                            level_d    = level_q + LEVEL_W'(1);
                        end
                    end else if (level_lose) begin
                        lives_d = lives_dec;
                        if (lives_dec == '0) begin
                            next_state = S_GAME_OVER;
                        end else begin
                            next_state = S_PRELEVEL;
                            if (RETRY_FROM_START != 0) level_d = '0;
                        end
                    end
                end
            end
            S_WIN, S_GAME_OVER: begin
                if (start_press) begin
                    next_state = S_START;
                    lives_d    = LIVES_INIT;
                    level_d    = '0;
                end
            end
            default: begin
                next_state = S_START;
                lives_d    = LIVES_INIT;
                level_d    = '0;
            end
        endcase

        restart_d = (next_state == S_PLAY) && (state != S_PLAY);
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state       <= S_START;
            level_q     <= '0;
            lives_q     <= LIVES_INIT;
            hold_cnt    <= '0;
            restart_q   <= 1'b0;
            start_prev  <= 1'b1;
            start_armed <= 1'b0;
        end else begin
            state       <= next_state;
            level_q     <= level_d;
            lives_q     <= lives_d;
            hold_cnt    <= hold_d;
            restart_q   <= restart_d;
            start_prev  <= start_button;
            start_armed <= start_armed | start_button;
        end
    end

    always_comb begin
        leds = '0;
        for (int unsigned i = 0; i < 4; i++) leds[6+i] = (32'(lives_q) == i);
        for (int unsigned i = 0; i < 6; i++) leds[i]   = (32'(level_q) == i);
    end

    assign screen        = state;
    assign level_index   = level_q;
    assign lives         = lives_q;
    assign level_restart = restart_q;
    assign level_enable  = (state == S_PLAY);
    assign show_hearts   = (state == S_PRELEVEL) || (state == S_PLAY);

endmodule
